// File: rtl/starflux_pkg.sv
// Shared types and constants for the starflux video pipeline: renderer FSM
// states, framebuffer geometry and the palette entries used for the ship.
package starflux_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0] colour_t;

  localparam colour_t COLOUR_SHIP = 3'b111;
  localparam colour_t COLOUR_BG   = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/ship_sprite_rom.sv
// Constant 8x8 ship bitmap; mask is the pixel at column dx of row dy.
// Only instantiated when SHIP_SPRITE_ROM_EN is defined.
module ship_sprite_rom (
  input  logic [2:0] dx,
  input  logic [2:0] dy,
  output logic       mask
);

  logic [7:0] row;

  always_comb begin
    row = 8'b0000_0000;
    case (dy)
      3'd0: row = 8'b0001_1000;
      3'd1: row = 8'b0001_1000;
      3'd2: row = 8'b0011_1100;
      3'd3: row = 8'b0111_1110;
      3'd4: row = 8'b1111_1111;
      3'd5: row = 8'b1111_1111;
      3'd6: row = 8'b1101_1011;
      3'd7: row = 8'b1000_0001;
      default: row = 8'b0000_0000;
    endcase
    mask = row[dx];
  end

endmodule

// File: rtl/ship_renderer.sv
// Erases the ship box at its last drawn x, then redraws it at the newly latched x,
// one pixel per clock. Optional sprite mask: define SHIP_SPRITE_ROM_EN.
module ship_renderer
  import starflux_pkg::*;
#(
  parameter int      SHIP_W      = 8,
  parameter int      SHIP_H      = 8,
  parameter int      SHIP_Y      = 110,
  parameter colour_t SHIP_COLOUR = COLOUR_SHIP,
  parameter colour_t BG_COLOUR   = COLOUR_BG
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] x_val,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int         DX_W  = $clog2(SHIP_W);
  localparam int         DY_W  = $clog2(SHIP_H);
  localparam logic [7:0] X_MAX = 8'(SCREEN_W - SHIP_W);
  localparam logic [6:0] Y_TOP = 7'(SHIP_Y);

  state_t          state, state_next;
  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;
  logic [7:0]      old_x, new_x;
  logic            drawn_valid;
  logic            last_px;
  logic            sprite_bit;

  // Both dimensions are powers of two, so the last pixel is all-ones in each counter.
  assign last_px = (&dx) & (&dy);

`ifdef SHIP_SPRITE_ROM_EN
  ship_sprite_rom u_sprite_rom (
    .dx   (dx),
    .dy   (dy),
    .mask (sprite_bit)
  );
`else
  assign sprite_bit = 1'b1;
`endif

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dx          <= '0;
      dy          <= '0;
      old_x       <= '0;
      new_x       <= '0;
      drawn_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick) begin
            new_x <= (x_val > X_MAX) ? X_MAX : x_val;
            dx    <= '0;
            dy    <= '0;
          end
        end
        ERASE, DRAW: begin
          // Counters wrap to zero after the last pixel, ready for the next pass.
          dx <= dx + 1'b1;
          if (&dx) dy <= dy + 1'b1;
          if (state == DRAW && last_px) begin
            old_x       <= new_x;
            drawn_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next = state;
    vga_x      = '0;
    vga_y      = '0;
    colour     = '0;
    plot       = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (frame_tick) state_next = drawn_valid ? ERASE : DRAW;
      end
      ERASE: begin
        vga_x  = old_x + 8'(dx);
        vga_y  = Y_TOP + 7'(dy);
        colour = BG_COLOUR;
        plot   = 1'b1;
        if (last_px) state_next = DRAW;
      end
      DRAW: begin
        vga_x  = new_x + 8'(dx);
        vga_y  = Y_TOP + 7'(dy);
        colour = SHIP_COLOUR;
        plot   = sprite_bit;
        if (last_px) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
